mcb_port_responder: RTL and testbench
=====================================

Name: mcb_port_responder

Overview:
- Synthesizable responder for one MCB user port (p0-style cmd/wr/rd FIFO interface), backed by on-chip RAM.
- Stands in for the DDR2 controller so initiator state machines (DDR test drivers, FPGALink bridges) can run in sim and on-board without external memory.
- Implements calibration delay, command/write/read FIFOs, masked writes and read latency.

Parameters:
- ADDR_W, 10, word-address width; the RAM holds 2**ADDR_W 64-bit words.
- CALIB_CYCLES, 64, cycles from reset release to calib_done high.
- READ_LAT, 4, cycles from read-command start to the first word pushed into the rd FIFO (minimum 1).
- CMD_DEPTH, 4, command FIFO depth.
- DATA_DEPTH, 64, depth of the wr and rd data FIFOs.

Ports:
- clk  in  1  port clock.
- reset  in  1  asynchronous, active-high reset.
- calib_done  out  1  high once calibration delay has elapsed.
- cmd_en  in  1  command push strobe.
- cmd_instr  in  3  000 write, 001 read, 010 write-AP, 011 read-AP, 1xx refresh.
- cmd_bl  in  6  burst length minus one (1..64 words).
- cmd_byte_addr  in  30  byte address.
- cmd_full, cmd_empty  out  1  command FIFO status.
- cmd_error  out  1  sticky; set when cmd_en occurs while full.
- wr_en  in  1  write-data push strobe.
- wr_data  in  64  write word.
- wr_mask  in  8  per-byte mask; 1 = byte not written.
- wr_full, wr_empty  out  1  write FIFO status.
- wr_count  out  7  write FIFO occupancy.
- wr_underrun  out  1  high while a write is stalled for data.
- wr_error  out  1  sticky; set when wr_en occurs while full.
- rd_en  in  1  read-data pop strobe.
- rd_data  out  64  head of the rd FIFO (first-word-fall-through).
- rd_full, rd_empty  out  1  read FIFO status.
- rd_count  out  7  read FIFO occupancy.
- rd_error  out  1  sticky; set when rd_en occurs while empty.

Behaviour:
- Reset values: all FIFOs cleared; calib_done=0; cmd_empty=wr_empty=rd_empty=1; all full flags, counts, errors and wr_underrun = 0; rd_data=0; FSM in CALIB.
- Asynchronous reset mid-operation aborts any burst. RAM contents are retained. Calibration reruns.
- Commands are accepted even before calib_done; they execute only after it.
- FIFOs:
  - A push when full is dropped and sets the matching *_error flag.
  - A pop when empty is ignored and sets rd_error.
  - Simultaneous push+pop when not full/empty leaves the count unchanged.
  - Counts update the cycle after the strobe.
- Word address = cmd_byte_addr[ADDR_W+2:3]. Bits [2:0] are ignored. The address increments per word and wraps modulo 2**ADDR_W.
- FSM states: CALIB, IDLE, WRITE, RD_WAIT, READ, REFRESH.
  - CALIB -> IDLE after CALIB_CYCLES; calib_done is set on entry to IDLE.
  - IDLE: if the cmd FIFO is not empty, pop the command and latch addr and remaining = bl+1.
    - instr[2]=1 -> REFRESH.
    - instr[0]=0 -> WRITE.
    - else -> RD_WAIT.
  - WRITE: each cycle the wr FIFO is non-empty, pop one word and write the RAM with wr_mask applied per byte. Decrement remaining; when it reaches 0 -> IDLE.
    - If the wr FIFO is empty, stall with wr_underrun=1. No timeout.
  - RD_WAIT: count READ_LAT-1 cycles -> READ.
  - READ: each cycle the rd FIFO is not full, push RAM[addr] and decrement remaining; at 0 -> IDLE.
    - If the rd FIFO is full, stall. No word is lost and no overflow occurs.
  - REFRESH: 8 idle cycles -> IDLE.
- One word per cycle peak in WRITE and READ. One command is in execution at a time; commands complete in order.
- Write-then-read to the same address returns the new data, because commands are strictly serialized.

Optional Feature:
- MCB_RESP_RANDOM_STALL_EN
  - Defined: a 16-bit LFSR (seed 16'hACE1, reloaded on reset) gates progress in WRITE and READ. When the LFSR LSB=1, that cycle does no transfer. Used to exercise initiator stall handling.
  - Undefined: no LFSR; full one-word-per-cycle throughput.

Decomposition:
- Package mcb_resp_pkg holds:
  - Instruction codes INSTR_WR, INSTR_RD, INSTR_WR_AP, INSTR_RD_AP, INSTR_REF.
  - Widths DATA_W=64, MASK_W=8, BL_W=6, BYTE_ADDR_W=30.
  - FSM state enumeration.
  - REFRESH_CYCLES=8.
- Sub-module sync_fifo (parameterized width/depth, count/full/empty, FWFT), instantiated three times: cmd, wr, rd.
- The RAM is inferred in the top level.

Test Plan:
- Reset, hold idle: calib_done rises exactly CALIB_CYCLES after reset release; rd_empty=1, all errors 0.
- Push data 3,4,5,6,7,8; write bl=5 to byte addr 16; then read bl=5 from addr 16; pop all: rd_data sequence 3..8, then rd_empty=1. The first rd push occurs READ_LAT cycles after the read command is popped.
- Write at addr 0 with data 64'hFFFF_FFFF_FFFF_FFFF, then write 64'h0 with wr_mask=8'h0F; read back: 64'h0000_0000_FFFF_FFFF.
- Issue write bl=3 with only 2 data words pushed: wr_underrun=1 while stalled. Push 2 more: the burst completes, wr_underrun=0, and the read returns all 4 words.
- Read bl=63 from addr (2**ADDR_W-2)*8 with rd_en low: the FIFO fills to 64 and words wrap to RAM[0]. Pop one extra word when empty: rd_error=1. A cmd_en with 5 commands pending: cmd_error=1.
- Assert reset mid-READ: all FIFOs empty and calib_done=0 immediately. After recalibration, a read of previously written data returns the retained RAM contents.

Source files
------------

// File: rtl/mcb_resp_pkg.sv
// ---------------------------------------------------------------------------
// mcb_resp_pkg
// Shared definitions for the MCB port responder: instruction encodings,
// interface widths, the sequencer state type and the layouts of the entries
// stored in the command and write-data FIFOs.
// ---------------------------------------------------------------------------
package mcb_resp_pkg;

  localparam int DATA_W         = 64;
  localparam int MASK_W         = 8;
  localparam int BL_W           = 6;
  localparam int BYTE_ADDR_W    = 30;
  localparam int INSTR_W        = 3;
  localparam int REFRESH_CYCLES = 8;

  localparam logic [INSTR_W-1:0] INSTR_WR    = 3'b000;
  localparam logic [INSTR_W-1:0] INSTR_RD    = 3'b001;
  localparam logic [INSTR_W-1:0] INSTR_WR_AP = 3'b010;
  localparam logic [INSTR_W-1:0] INSTR_RD_AP = 3'b011;
  localparam logic [INSTR_W-1:0] INSTR_REF   = 3'b100;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ,
    ST_REFRESH
  } state_e;

  // One queued command as it sits in the command FIFO.
  typedef struct packed {
    logic [INSTR_W-1:0]     instr;
    logic [BL_W-1:0]        bl;
    logic [BYTE_ADDR_W-1:0] byteAddr;
  } cmd_t;

  // One write word together with its byte mask (1 = keep old byte).
  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } wr_word_t;

  // Refresh is recognised by the top instruction bit alone (1xx).
  function automatic logic isRefresh(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1];
  endfunction

  // Bit 0 separates reads from writes, auto-precharge variants included.
  function automatic logic isRead(input logic [INSTR_W-1:0] instr);
    return instr[0] == INSTR_RD[0];
  endfunction

endpackage

// File: rtl/mcb_port_responder_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used for the command, write-data
// and read-data queues of the MCB port responder.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push_i       push strobe; dropped when full
//   pushData_i   word to push
//   pop_i        pop strobe; ignored when empty
//   popData_o    head of queue, forced to zero while empty
//   full_o       occupancy equals DEPTH
//   empty_o      occupancy is zero
//   count_o      occupancy, updated the cycle after a strobe
// ---------------------------------------------------------------------------
module sync_fifo
  import mcb_resp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // Pointers wrap explicitly so depths that are not a power of two also work.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Status flags and the qualified strobes; a blocked strobe has no effect here,
  // the owner of the FIFO decides whether it is an error.
  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    doPush  = push_i && !full_o;
    doPop   = pop_i && !empty_o;
  end

  // Next-state for pointers and occupancy; push and pop together keep the count.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= pushData_i;
  end

  // Fall-through head, held at zero while empty so the port reads clean.
  always_comb begin
    popData_o = empty_o ? '0 : mem[rdPtr_q];
    count_o   = count_q;
  end

endmodule

// File: rtl/mcb_port_responder.sv
// ---------------------------------------------------------------------------
// mcb_port_responder
// On-chip RAM stand-in for one MCB user port. Accepts p0-style commands,
// write data and read pops, and executes commands one at a time against an
// inferred 2**ADDR_W x 64-bit RAM after a calibration delay.
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   calib_done                          high once calibration has elapsed
//   cmd_en/cmd_instr/cmd_bl/cmd_byte_addr   command push
//   cmd_full/cmd_empty/cmd_error        command FIFO status, sticky overflow
//   wr_en/wr_data/wr_mask               write-data push (mask 1 = keep byte)
//   wr_full/wr_empty/wr_count           write FIFO status
//   wr_underrun                         write burst stalled waiting for data
//   wr_error                            sticky write FIFO overflow
//   rd_en/rd_data                       read pop, fall-through head
//   rd_full/rd_empty/rd_count           read FIFO status
//   rd_error                            sticky pop-while-empty
//
// Build option: MCB_RESP_RANDOM_STALL_EN adds an LFSR that randomly withholds
// transfers in the WRITE and READ states.
// ---------------------------------------------------------------------------
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int READ_LAT     = 4,
  parameter int CMD_DEPTH    = 4,
  parameter int DATA_DEPTH   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   calib_done,
  input  logic                   cmd_en,
  input  logic [INSTR_W-1:0]     cmd_instr,
  input  logic [BL_W-1:0]        cmd_bl,
  input  logic [BYTE_ADDR_W-1:0] cmd_byte_addr,
  output logic                   cmd_full,
  output logic                   cmd_empty,
  output logic                   cmd_error,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [MASK_W-1:0]      wr_mask,
  output logic                   wr_full,
  output logic                   wr_empty,
  output logic [6:0]             wr_count,
  output logic                   wr_underrun,
  output logic                   wr_error,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_full,
  output logic                   rd_empty,
  output logic [6:0]             rd_count,
  output logic                   rd_error
);

  localparam int CMD_W      = $bits(cmd_t);
  localparam int WR_W       = $bits(wr_word_t);
  localparam int CMD_CNT_W  = $clog2(CMD_DEPTH + 1);

  state_e                state_q, state_d;
  logic [31:0]           timer_q, timer_d;
  logic [ADDR_W-1:0]     wordAddr_q, wordAddr_d;
  logic [BL_W:0]         remaining_q, remaining_d;
  logic                  calibDone_q, calibDone_d;
  logic                  cmdError_q, wrError_q, rdError_q;

  cmd_t                  cmdIn, cmdHead;
  wr_word_t              wrIn, wrHead;
  logic                  cmdPop, wrPop, rdPush, ramWe, xferOk;
  logic [CMD_CNT_W-1:0]  unusedCmdCount;
  logic [BYTE_ADDR_W-ADDR_W:0] unusedCmdBits;
  logic [DATA_W-1:0]     ram [2**ADDR_W];

  assign cmdIn = '{instr: cmd_instr, bl: cmd_bl, byteAddr: cmd_byte_addr};
  assign wrIn  = '{mask: wr_mask, data: wr_data};

  // Low byte-offset bits, high address bits and the auto-precharge bit carry
  // no meaning for an on-chip RAM.
  assign unusedCmdBits = {cmdHead.instr[1],
                          cmdHead.byteAddr[BYTE_ADDR_W-1:ADDR_W+3],
                          cmdHead.byteAddr[2:0]};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .CNT_W(CMD_CNT_W)) u_cmd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_en),
    .pushData_i (cmdIn),
    .pop_i      (cmdPop),
    .popData_o  (cmdHead),
    .full_o     (cmd_full),
    .empty_o    (cmd_empty),
    .count_o    (unusedCmdCount)
  );

  sync_fifo #(.WIDTH(WR_W), .DEPTH(DATA_DEPTH), .CNT_W(7)) u_wr_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (wr_en),
    .pushData_i (wrIn),
    .pop_i      (wrPop),
    .popData_o  (wrHead),
    .full_o     (wr_full),
    .empty_o    (wr_empty),
    .count_o    (wr_count)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH), .CNT_W(7)) u_rd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (rdPush),
    .pushData_i (ram[wordAddr_q]),
    .pop_i      (rd_en),
    .popData_o  (rd_data),
    .full_o     (rd_full),
    .empty_o    (rd_empty),
    .count_o    (rd_count)
  );

`ifdef MCB_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Maximal-length 16-bit Fibonacci LFSR (taps 16,14,13,11) advanced every cycle.
  always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // LFSR register, reseeded on every reset so stall patterns are repeatable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign xferOk = ~lfsr_q[0];
`else
  assign xferOk = 1'b1;
`endif

  // Sequencer next-state and strobes. A single timer is shared by the
  // calibration, read-latency and refresh waits since they never overlap.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    wordAddr_d  = wordAddr_q;
    remaining_d = remaining_q;
    calibDone_d = calibDone_q;
    cmdPop      = 1'b0;
    wrPop       = 1'b0;
    rdPush      = 1'b0;
    ramWe       = 1'b0;
    wr_underrun = 1'b0;
    case (state_q)
      ST_CALIB: begin
        if (timer_q == 32'(CALIB_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          calibDone_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_IDLE: begin
        if (!cmd_empty) begin
          cmdPop      = 1'b1;
          wordAddr_d  = cmdHead.byteAddr[ADDR_W+2:3];
          remaining_d = {1'b0, cmdHead.bl} + 1'b1;
          timer_d     = '0;
          if (isRefresh(cmdHead.instr))  state_d = ST_REFRESH;
          else if (!isRead(cmdHead.instr)) state_d = ST_WRITE;
          else if (READ_LAT > 1)         state_d = ST_RD_WAIT;
          else                           state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_empty) begin
          wr_underrun = 1'b1;
        end else if (xferOk) begin
          wrPop       = 1'b1;
          ramWe       = 1'b1;
          wordAddr_d  = wordAddr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (BL_W+1)'(1)) state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (timer_q == 32'(READ_LAT - 2)) state_d = ST_READ;
        else                              timer_d = timer_q + 32'd1;
      end
      ST_READ: begin
        if (!rd_full && xferOk) begin
          rdPush      = 1'b1;
          wordAddr_d  = wordAddr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (BL_W+1)'(1)) state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (timer_q == 32'(REFRESH_CYCLES - 1)) state_d = ST_IDLE;
        else                                    timer_d = timer_q + 32'd1;
      end
      default: state_d = ST_CALIB;
    endcase
  end

  // Sequencer registers; reset drops any burst in progress and reruns calibration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CALIB;
      timer_q     <= '0;
      wordAddr_q  <= '0;
      remaining_q <= '0;
      calibDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wordAddr_q  <= wordAddr_d;
      remaining_q <= remaining_d;
      calibDone_q <= calibDone_d;
    end
  end

  // Sticky misuse flags for the three host-facing strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmdError_q <= 1'b0;
      wrError_q  <= 1'b0;
      rdError_q  <= 1'b0;
    end else begin
      if (cmd_en && cmd_full) cmdError_q <= 1'b1;
      if (wr_en && wr_full)   wrError_q  <= 1'b1;
      if (rd_en && rd_empty)  rdError_q  <= 1'b1;
    end
  end

  // Byte-masked RAM write; the array is never reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wrHead.mask[b]) ram[wordAddr_q][b*8 +: 8] <= wrHead.data[b*8 +: 8];
      end
    end
  end

  assign calib_done = calibDone_q;
  assign cmd_error  = cmdError_q;
  assign wr_error   = wrError_q;
  assign rd_error   = rdError_q;

endmodule

// File: tb/tb_mcb_port_responder.sv
// ---------------------------------------------------------------------------
// tb_mcb_port_responder
// Directed bench for the MCB port responder: calibration timing, burst write
// and read-back, byte masking, write underrun, read FIFO fill with address
// wrap, FIFO error flags and reset in the middle of a read burst.
// ---------------------------------------------------------------------------
module tb_mcb_port_responder;
  import mcb_resp_pkg::*;

  localparam int ADDR_W       = 10;
  localparam int CALIB_CYCLES = 64;
  localparam int READ_LAT     = 4;
  localparam int CMD_DEPTH    = 4;
  localparam int DATA_DEPTH   = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   calib_done;
  logic                   cmd_en;
  logic [INSTR_W-1:0]     cmd_instr;
  logic [BL_W-1:0]        cmd_bl;
  logic [BYTE_ADDR_W-1:0] cmd_byte_addr;
  logic                   cmd_full, cmd_empty, cmd_error;
  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic [MASK_W-1:0]      wr_mask;
  logic                   wr_full, wr_empty, wr_underrun, wr_error;
  logic [6:0]             wr_count;
  logic                   rd_en;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_full, rd_empty, rd_error;
  logic [6:0]             rd_count;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] expWrap [10];

  mcb_port_responder #(
    .ADDR_W       (ADDR_W),
    .CALIB_CYCLES (CALIB_CYCLES),
    .READ_LAT     (READ_LAT),
    .CMD_DEPTH    (CMD_DEPTH),
    .DATA_DEPTH   (DATA_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .calib_done    (calib_done),
    .cmd_en        (cmd_en),
    .cmd_instr     (cmd_instr),
    .cmd_bl        (cmd_bl),
    .cmd_byte_addr (cmd_byte_addr),
    .cmd_full      (cmd_full),
    .cmd_empty     (cmd_empty),
    .cmd_error     (cmd_error),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .wr_full       (wr_full),
    .wr_empty      (wr_empty),
    .wr_count      (wr_count),
    .wr_underrun   (wr_underrun),
    .wr_error      (wr_error),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_full       (rd_full),
    .rd_empty      (rd_empty),
    .rd_count      (rd_count),
    .rd_error      (rd_error)
  );

  // 100 MHz port clock.
  always #5 clk = ~clk;

  // Drive one cycle of strobes, then release them 1 ns after the edge.
  task automatic applyStimulus(input logic cEn, input logic [INSTR_W-1:0] instr,
                               input logic [BL_W-1:0] bl, input logic [BYTE_ADDR_W-1:0] addr,
                               input logic wEn, input logic [DATA_W-1:0] wData,
                               input logic [MASK_W-1:0] wMask, input logic rEn);
    cmd_en        = cEn;
    cmd_instr     = instr;
    cmd_bl        = bl;
    cmd_byte_addr = addr;
    wr_en         = wEn;
    wr_data       = wData;
    wr_mask       = wMask;
    rd_en         = rEn;
    @(posedge clk);
    #1;
    cmd_en = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic pushCmd(input logic [INSTR_W-1:0] instr, input logic [BL_W-1:0] bl,
                         input logic [BYTE_ADDR_W-1:0] addr);
    applyStimulus(1'b1, instr, bl, addr, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] data, input logic [MASK_W-1:0] mask);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, data, mask, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One scored comparison.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hard time limit in case the sequence itself stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cmd_en = 1'b0; cmd_instr = '0; cmd_bl = '0; cmd_byte_addr = '0;
    wr_en = 1'b0; wr_data = '0; wr_mask = '0; rd_en = 1'b0;
    expWrap = '{64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_calib", 64'(calib_done), 64'd0);
    checkOutput("rst_empties", 64'({cmd_empty, wr_empty, rd_empty}), 64'd7);
    checkOutput("rst_fulls", 64'({cmd_full, wr_full, rd_full}), 64'd0);
    checkOutput("rst_errors", 64'({cmd_error, wr_error, rd_error, wr_underrun}), 64'd0);
    checkOutput("rst_counts", 64'({wr_count, rd_count}), 64'd0);
    checkOutput("rst_rd_data", rd_data, 64'd0);

    // Calibration: calib_done rises on the CALIB_CYCLES-th edge after release.
    reset = 1'b0;
    idleCycles(CALIB_CYCLES - 1);
    checkOutput("calib_early", 64'(calib_done), 64'd0);
    idleCycles(1);
    checkOutput("calib_rise", 64'(calib_done), 64'd1);

    // Burst write of 3..8 to word 2, then read back with latency check.
    for (int i = 3; i <= 8; i++) pushWord(64'(i), 8'h00);
    checkOutput("wr_count_6", 64'(wr_count), 64'd6);
    pushCmd(INSTR_WR, 6'd5, 30'd16);
    for (int i = 0; i < 100 && !(wr_empty && cmd_empty); i++) idleCycles(1);
    checkOutput("wr_burst_drain", 64'(wr_empty && cmd_empty), 64'd1);
    pushCmd(INSTR_RD, 6'd5, 30'd16);
    idleCycles(1);
    checkOutput("rd_cmd_popped", 64'(cmd_empty), 64'd1);
    idleCycles(READ_LAT - 1);
    checkOutput("rd_lat_before", 64'(rd_count), 64'd0);
    idleCycles(1);
    checkOutput("rd_lat_first", 64'(rd_count), 64'd1);
    idleCycles(5);
    checkOutput("rd_count_6", 64'(rd_count), 64'd6);
    for (int i = 3; i <= 8; i++) begin
      checkOutput($sformatf("rd_word_%0d", i), rd_data, 64'(i));
      popWord();
    end
    checkOutput("rd_drained", 64'({rd_empty, rd_error}), 64'd2);

    // Byte mask: second write keeps bytes 0..3 of the first.
    pushWord(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    pushWord(64'h0, 8'h0F);
    pushCmd(INSTR_WR, 6'd0, 30'd0);
    pushCmd(INSTR_WR_AP, 6'd0, 30'd0);
    pushCmd(INSTR_RD_AP, 6'd0, 30'd0);
    for (int i = 0; i < 50 && rd_count != 7'd1; i++) idleCycles(1);
    checkOutput("mask_rd_count", 64'(rd_count), 64'd1);
    checkOutput("mask_merge", rd_data, 64'h0000_0000_FFFF_FFFF);
    popWord();

    // Write underrun: four-word burst with only two words available.
    pushWord(64'hA1, 8'h00);
    pushWord(64'hA2, 8'h00);
    pushCmd(INSTR_WR, 6'd3, 30'd800);
    idleCycles(6);
    checkOutput("underrun_stall", 64'({wr_underrun, wr_empty}), 64'd3);
    pushWord(64'hA3, 8'h00);
    pushWord(64'hA4, 8'h00);
    idleCycles(2);
    checkOutput("underrun_clear", 64'({wr_underrun, wr_empty}), 64'd1);
    pushCmd(INSTR_RD, 6'd3, 30'd800);
    for (int i = 0; i < 50 && rd_count != 7'd4; i++) idleCycles(1);
    checkOutput("underrun_rd_count", 64'(rd_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("underrun_word_%0d", i), rd_data, 64'(8'hA1 + i));
      popWord();
    end

    // Write wrapping past the top of RAM, then a 64-word read filling the rd FIFO.
    for (int i = 0; i < 4; i++) pushWord(64'(8'hB0 + i), 8'h00);
    pushCmd(INSTR_WR, 6'd3, 30'((2**ADDR_W - 2) * 8));
    for (int i = 0; i < 50 && !(wr_empty && cmd_empty); i++) idleCycles(1);
    idleCycles(1);
    pushCmd(INSTR_RD, 6'd63, 30'((2**ADDR_W - 2) * 8));
    for (int i = 0; i < 200 && rd_count != 7'd64; i++) idleCycles(1);
    checkOutput("fill_count", 64'(rd_count), 64'd64);
    checkOutput("fill_full", 64'(rd_full), 64'd1);
    idleCycles(5);
    checkOutput("fill_hold", 64'({rd_count, rd_error}), 64'({7'd64, 1'b0}));
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("wrap_word_%0d", i), rd_data, expWrap[i]);
      popWord();
    end
    for (int i = 0; i < 54; i++) popWord();
    checkOutput("fill_drained", 64'({rd_empty, rd_error}), 64'd2);
    popWord();
    checkOutput("rd_underflow_err", 64'({rd_error, rd_count}), 64'({1'b1, 7'd0}));

    // Command overflow: one write stalled for data plus four queued refreshes.
    pushCmd(INSTR_WR, 6'd0, 30'd8);
    idleCycles(2);
    checkOutput("ovf_cmd_taken", 64'({cmd_empty, wr_underrun}), 64'd3);
    for (int i = 0; i < CMD_DEPTH; i++) pushCmd(INSTR_REF, 6'd0, 30'd0);
    checkOutput("ovf_full", 64'({cmd_full, cmd_error}), 64'd2);
    pushCmd(INSTR_REF, 6'd0, 30'd0);
    checkOutput("ovf_error", 64'(cmd_error), 64'd1);
    pushWord(64'hC1, 8'h00);
    for (int i = 0; i < 100 && !cmd_empty; i++) idleCycles(1);
    idleCycles(REFRESH_CYCLES + 2);
    checkOutput("ovf_sticky", 64'({cmd_error, cmd_empty}), 64'd3);

    // Reset in the middle of a read burst; RAM contents survive.
    pushCmd(INSTR_RD, 6'd63, 30'd0);
    for (int i = 0; i < 50 && rd_count < 7'd3; i++) idleCycles(1);
    checkOutput("midrd_started", 64'(rd_count >= 7'd3), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midrd_calib", 64'(calib_done), 64'd0);
    checkOutput("midrd_empties", 64'({cmd_empty, wr_empty, rd_empty}), 64'd7);
    checkOutput("midrd_counts", 64'({wr_count, rd_count}), 64'd0);
    checkOutput("midrd_errors", 64'({cmd_error, wr_error, rd_error}), 64'd0);
    checkOutput("midrd_rd_data", rd_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < CALIB_CYCLES + 10 && !calib_done; i++) idleCycles(1);
    checkOutput("recal_done", 64'(calib_done), 64'd1);
    pushCmd(INSTR_RD, 6'd1, 30'd16);
    for (int i = 0; i < 50 && rd_count != 7'd2; i++) idleCycles(1);
    checkOutput("retain_count", 64'(rd_count), 64'd2);
    checkOutput("retain_word_0", rd_data, 64'd3);
    popWord();
    checkOutput("retain_word_1", rd_data, 64'd4);
    popWord();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
